dcp_pkt_arbiter: RTL
====================

DCP_PKT_ARBITER -- requirements
Module: dcp_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the payload width per beat.
REQ-003 SHALL have parameter MAX_BEATS, default 1024, meaning the maximum beats per packet before forced release.
REQ-004 SHALL have port iClk, input, 1 bit: the single clock.
REQ-005 SHALL have port iRst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port iFlush, input, 1 bit: synchronous abort of the current grant.
REQ-007 SHALL have port iReqVld, input, NUM_REQ bits: per-requester beat valid.
REQ-008 SHALL have port iReqPld, input, NUM_REQ*DATA_WIDTH bits: per-requester payload, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port iReqLast, input, NUM_REQ bits: per-requester end-of-packet.
REQ-010 SHALL have port oReqRdy, output, NUM_REQ bits: per-requester ready.
REQ-011 SHALL have port oOutVld, output, 1 bit: beat valid toward the shared DcpFifo.
REQ-012 SHALL have port oOutPld, output, DATA_WIDTH bits: beat payload toward the shared DcpFifo.
REQ-013 SHALL have port oOutLast, output, 1 bit: end-of-packet toward the shared DcpFifo.
REQ-014 SHALL have port iOutRdy, input, 1 bit: ready from the shared DcpFifo.
REQ-015 SHALL have port oGrant, output, NUM_REQ bits: one-hot current owner, all zero when idle.
REQ-016 SHALL have port oErrOversize, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and LOCKED; handshake on a port = Vld & Rdy in the same cycle.
REQ-018 In IDLE, any iReqVld bit set SHALL select the first set requester at or after round-robin pointer PTR (wrapping NUM_REQ-1 to 0), register it into oGrant, and move to LOCKED next cycle.
REQ-019 In IDLE, oOutVld and all oReqRdy bits SHALL be 0, giving a fixed one-cycle arbitration bubble per packet.
REQ-020 In LOCKED with owner g: oOutVld = iReqVld[g], oOutPld = iReqPld[g], oOutLast = iReqLast[g] | forced, oReqRdy[g] = iOutRdy, all other oReqRdy bits = 0; this path is combinational.
REQ-021 Grant SHALL be held across valid gaps; only Last handshake, forced release, flush, or reset releases it.
REQ-022 On an output handshake with oOutLast=1, the FSM SHALL return to IDLE, clear oGrant, and set PTR = (g+1) mod NUM_REQ.
REQ-023 A beat counter SHALL clear on entry to LOCKED and increment on each output handshake; it is $clog2(MAX_BEATS+1) bits wide and never wraps.
REQ-024 forced SHALL be 1 when the counter equals MAX_BEATS-1 and iReqLast[g]=0; that handshake releases per REQ-022 and pulses oErrOversize for one cycle after it.
REQ-025 The requester's remaining beats after a forced release SHALL be treated as a new packet in later arbitration.
REQ-026 iFlush=1 SHALL override everything: next cycle IDLE, oGrant=0, counter=0, PTR unchanged, no oErrOversize; while asserted, oOutVld and oReqRdy SHALL be 0.
REQ-027 Payload and Last SHALL never be modified or reordered except for the forced Last of REQ-024.

Reset
REQ-028 While iRst_n=0: FSM=IDLE, PTR=0, counter=0, oGrant=0, oErrOversize=0, oOutVld=0, oReqRdy=0; reset mid-packet discards ownership with no error pulse.
REQ-029 The first arbitration after reset release SHALL take place in the first iClk edge with iRst_n=1.

Verification
REQ-030 Reset release, iReqVld=4'b0110, iOutRdy=1 -> cycle 1 oGrant=0010, beats from requester 1 pass; after Last, one idle cycle, then oGrant=0100.
REQ-031 All four requesters hold 3-beat packets continuously -> grants 0001,0010,0100,1000,0001 in order, each packet 3 beats plus one bubble cycle.
REQ-032 Owner drops iReqVld mid-packet for 5 cycles while requester 3 is valid -> oGrant stays unchanged, oReqRdy[3]=0, packet resumes intact.
REQ-033 MAX_BEATS=4, requester 0 sends 6 beats without Last -> beat 4 carries oOutLast=1, oErrOversize pulses once, beats 5-6 re-arbitrate as a new packet.
REQ-034 iOutRdy=0 for 10 cycles mid-packet, then iFlush pulse -> oOutVld=0 next cycle, oGrant=0, PTR unchanged, no lost or duplicated handshakes before the flush.

Source files
------------

// File: rtl/dcp_pkt_arbiter.sv
// Packet-level round-robin arbiter: locks one requester onto the shared DcpFifo
// port from grant until its Last beat, a forced oversize release, or a flush.
module dcp_pkt_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 1024
) (
    input  logic                          iClk,
    input  logic                          iRst_n,
    input  logic                          iFlush,
    input  logic [NUM_REQ-1:0]            iReqVld,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iReqPld,
    input  logic [NUM_REQ-1:0]            iReqLast,
    output logic [NUM_REQ-1:0]            oReqRdy,
    output logic                          oOutVld,
    output logic [DATA_WIDTH-1:0]         oOutPld,
    output logic                          oOutLast,
    input  logic                          iOutRdy,
    output logic [NUM_REQ-1:0]            oGrant,
    output logic                          oErrOversize
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             pick_vld;
    logic             forced;
    logic             out_hs;
    logic             pkt_done;

    // Index arithmetic modulo NUM_REQ, valid for any NUM_REQ (not only powers of two).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scanning from the farthest offset down lets the nearest requester at or after
    // ptr overwrite any earlier hit, so the last assignment is the round-robin winner.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that leaves one
        // unassigned would make synthesis hold its old value in a latch.
        pick_vld = 1'b0;
        pick_idx = ptr;
        cand_idx = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_idx = wrap_add(ptr, i);
            if (iReqVld[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register
            // samples pre-edge values regardless of the order the blocks are evaluated.
            state <= state_nxt;
        end
    end

    // FSM next-state logic; flush wins over both arbitration and release.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!iFlush && pick_vld) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (iFlush || pkt_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: combinational pass-through from the owner to the shared port.
    always_comb begin
        oOutVld  = 1'b0;
        oOutLast = 1'b0;
        oOutPld  = '0;
        oReqRdy  = '0;
        forced   = 1'b0;
        if (state == ST_LOCKED && !iFlush) begin
            forced         = (beat_cnt == CNT_LAST) && !iReqLast[owner];
            oOutVld        = iReqVld[owner];
            oOutLast       = iReqLast[owner] | forced;
            oReqRdy[owner] = iOutRdy;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (owner == IDX_W'(k)) begin
                    oOutPld = iReqPld[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign out_hs   = oOutVld & iOutRdy;
    assign pkt_done = out_hs & oOutLast;

    // Ownership, round-robin pointer, beat counter and the oversize pulse.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            owner        <= '0;
            oGrant       <= '0;
            ptr          <= '0;
            beat_cnt     <= '0;
            oErrOversize <= 1'b0;
        end else begin
            oErrOversize <= 1'b0;
            if (iFlush) begin
                oGrant   <= '0;
                beat_cnt <= '0;
            end else if (state == ST_IDLE) begin
                if (pick_vld) begin
                    owner    <= pick_idx;
                    oGrant   <= NUM_REQ'(1) << pick_idx;
                    beat_cnt <= '0;
                end
            end else if (out_hs) begin
                if (oOutLast) begin
                    oGrant       <= '0;
                    ptr          <= wrap_add(owner, 1);
                    beat_cnt     <= '0;
                    oErrOversize <= forced;
                end else if (beat_cnt != CNT_MAX) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
